// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants, state codes and command decode for countdown_timer
package timer_pkg;

  localparam logic [7:0] SEC_LIMIT_DEF = 8'd59;
  localparam logic [7:0] MAX_HOURS_DEF = 8'd99;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_PAUSED = 2'd1;
  localparam state_t ST_RUN    = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_TICK,
    CMD_START,
    CMD_STOP,
    CMD_LOAD
  } cmd_e;

  // Only the highest-priority strobe of a cycle takes effect.
  function automatic cmd_e decode_cmd(input logic load, input logic stop,
                                      input logic start, input logic tick);
    if (load)       return CMD_LOAD;
    else if (stop)  return CMD_STOP;
    else if (start) return CMD_START;
    else if (tick)  return CMD_TICK;
    else            return CMD_NONE;
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/down_mod_counter.sv
// rtl/down_mod_counter.sv - loadable 8-bit down counter with borrow chain output
module down_mod_counter #(
  parameter logic [7:0] LIMIT = 8'd59,
  parameter bit         WRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       borrow_in_i,
  output logic [7:0] value_o,
  output logic       zero_o,
  output logic       borrow_out_o
);

  logic [7:0] value_q, value_d;

  // A borrow at zero reloads LIMIT and passes the borrow upward; without WRAP it sticks at zero.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (borrow_in_i) begin
      if (value_q == 8'd0) value_d = WRAP ? LIMIT : 8'd0;
      else                 value_d = value_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= 8'd0;
    else     value_q <= value_d;
  end

  assign value_o      = value_q;
  assign zero_o       = (value_q == 8'd0);
  assign borrow_out_o = borrow_in_i & zero_o;

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - HH:MM:SS countdown timer with run/pause FSM and expiry pulse
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic [7:0] MAX_HOURS = MAX_HOURS_DEF,
  parameter logic [7:0] SEC_LIMIT = SEC_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_h,
  input  logic [7:0] load_m,
  input  logic [7:0] load_s,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       running,
  output logic       expired,
  output logic       done
);

  state_t     state_q, state_d;
  logic       expired_q, expired_d;
  cmd_e       cmd;
  logic [7:0] ld_h, ld_m, ld_s;
  logic       cnt_load, dec_en;
  logic       sec_zero, min_zero, hr_zero;
  logic       sec_borrow, min_borrow, hr_borrow;
  logic       terminal;

  assign cmd      = decode_cmd(load, stop, start, tick);
  assign ld_h     = sat8(load_h, MAX_HOURS);
  assign ld_m     = sat8(load_m, SEC_LIMIT);
  assign ld_s     = sat8(load_s, SEC_LIMIT);
  assign cnt_load = (cmd == CMD_LOAD);
  assign dec_en   = (cmd == CMD_TICK) && (state_q == ST_RUN);

  down_mod_counter #(.LIMIT(SEC_LIMIT), .WRAP(1'b1)) u_sec (
    .clk          (clk),
    .rst          (rst),
    .load_i       (cnt_load),
    .load_val_i   (ld_s),
    .borrow_in_i  (dec_en),
    .value_o      (seconds),
    .zero_o       (sec_zero),
    .borrow_out_o (sec_borrow)
  );

  down_mod_counter #(.LIMIT(SEC_LIMIT), .WRAP(1'b1)) u_min (
    .clk          (clk),
    .rst          (rst),
    .load_i       (cnt_load),
    .load_val_i   (ld_m),
    .borrow_in_i  (sec_borrow),
    .value_o      (minutes),
    .zero_o       (min_zero),
    .borrow_out_o (min_borrow)
  );

  down_mod_counter #(.LIMIT(MAX_HOURS), .WRAP(1'b0)) u_hr (
    .clk          (clk),
    .rst          (rst),
    .load_i       (cnt_load),
    .load_val_i   (ld_h),
    .borrow_in_i  (min_borrow),
    .value_o      (hours),
    .zero_o       (hr_zero),
    .borrow_out_o (hr_borrow)
  );

  // hr_borrow means a decrement at 00:00:00; RUN never holds zero, so it only backs up terminal.
  assign terminal = (dec_en && (seconds == 8'd1) && min_zero && hr_zero) || hr_borrow;

  always_comb begin
    state_d   = state_q;
    expired_d = 1'b0;
    case (cmd)
      CMD_LOAD: begin
        state_d = ((ld_h | ld_m | ld_s) != 8'd0) ? ST_PAUSED : ST_IDLE;
      end
      CMD_STOP: begin
        if (state_q == ST_RUN) state_d = ST_PAUSED;
      end
      CMD_START: begin
        if (state_q == ST_PAUSED) state_d = ST_RUN;
      end
      CMD_TICK: begin
        if (terminal) begin
          state_d   = ST_DONE;
          expired_d = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      expired_q <= expired_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer against a total-seconds model
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_h = 8'd0;
  logic [7:0] load_m = 8'd0;
  logic [7:0] load_s = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] hours, minutes, seconds;
  logic       running, expired, done;

  countdown_timer dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (load),
    .load_h  (load_h),
    .load_m  (load_m),
    .load_s  (load_s),
    .start   (start),
    .stop    (stop),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .running (running),
    .expired (expired),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int m;
    int s;
    int run;
    int exp;
    int dn;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the count is one integer of seconds; modes are plain words.
  int    m_total = 0;
  string m_mode  = "IDLE";

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("hours",   int'(hours),   e.h);
      check("minutes", int'(minutes), e.m);
      check("seconds", int'(seconds), e.s);
      check("running", int'(running), e.run);
      check("expired", int'(expired), e.exp);
      check("done",    int'(done),    e.dn);
    end
  end

  task automatic step(input logic r, input logic ld, input int lh, input int lm, input int ls,
                      input logic sta, input logic sto, input logic tk);
    exp_t e;
    int   pulse;
    int   h, m, s;
    @(negedge clk);
    #1;
    rst = r; load = ld; load_h = lh[7:0]; load_m = lm[7:0]; load_s = ls[7:0];
    start = sta; stop = sto; tick = tk;
    pulse = 0;
    if (r) begin
      m_total = 0;
      m_mode  = "IDLE";
    end else if (ld) begin
      h = (lh > 99) ? 99 : lh;
      m = (lm > 59) ? 59 : lm;
      s = (ls > 59) ? 59 : ls;
      m_total = h * 3600 + m * 60 + s;
      m_mode  = (m_total != 0) ? "PAUSED" : "IDLE";
    end else if (sto) begin
      if (m_mode == "RUN") m_mode = "PAUSED";
    end else if (sta) begin
      if (m_mode == "PAUSED") m_mode = "RUN";
    end else if (tk && m_mode == "RUN") begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_mode = "DONE";
        pulse  = 1;
      end
    end
    e.h   = m_total / 3600;
    e.m   = (m_total % 3600) / 60;
    e.s   = m_total % 60;
    e.run = (m_mode == "RUN") ? 1 : 0;
    e.exp = pulse;
    e.dn  = (m_mode == "DONE") ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_load(input int h, input int m, input int s, input logic tk);
    step(1'b0, 1'b1, h, m, s, 1'b0, 1'b0, tk);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_stop(input logic tk);
    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, tk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    do_idle(2);
    do_tick(2);

    do_load(0, 1, 5, 1'b0); do_start(); do_tick(3);

    do_load(1, 0, 0, 1'b0); do_start(); do_tick(1);
    do_stop(1'b0); do_tick(5); do_start(); do_tick(1);

    do_load(0, 0, 2, 1'b0); do_start(); do_tick(2); do_idle(1);
    do_tick(2); do_start(); do_tick(1);

    do_load(120, 75, 80, 1'b0); do_idle(1);
    do_load(0, 0, 0, 1'b0); do_start(); do_tick(2);

    do_load(0, 10, 8, 1'b0); do_start(); do_tick(1);
    do_load(0, 0, 9, 1'b1); do_tick(1);
    do_start(); do_stop(1'b1); do_tick(1);
    do_start(); do_tick(1);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    do_load(0, 10, 8, 1'b0); do_start(); do_tick(1);
    step(1'b1, 1'b1, 5, 5, 5, 1'b1, 1'b0, 1'b1);
    do_idle(1);

    for (int i = 0; i < 4000; i++) begin
      logic r, ld, sta, sto, tk;
      int   lh, lm, ls;
      r   = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 59) == 0);
      sta = ($urandom_range(0, 9) == 0);
      sto = ($urandom_range(0, 39) == 0);
      tk  = ($urandom_range(0, 1) == 1);
      lh  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 130) : 0;
      lm  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 1);
      ls  = $urandom_range(0, 90);
      step(r, ld, lh, lm, ls, sta, sto, tk);
    end

    do_idle(1);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
